// File: rtl/fetch_prefetch_buf.sv
// Instruction prefetch buffer: a DEPTH-entry FIFO fed by a split request/response
// bus with several reads in flight; redirects flush the FIFO and drop stale responses.
module fetch_prefetch_buf #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                PC_STEP  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       jump_flag_i,
  input  logic [ADDR_W-1:0]          jump_addr_i,
  input  logic                       jtag_reset_flag_i,
  input  logic                       hold_i,
  output logic                       req_o,
  output logic [ADDR_W-1:0]          addr_o,
  input  logic                       gnt_i,
  input  logic                       rvalid_i,
  input  logic [DATA_W-1:0]          rdata_i,
  output logic                       inst_valid_o,
  output logic [DATA_W-1:0]          inst_o,
  output logic [ADDR_W-1:0]          inst_addr_o,
  output logic [$clog2(DEPTH):0]     level_o
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int PW = $clog2(DEPTH);
  localparam int SW = CW + 1;
  localparam logic [DATA_W-1:0] NOP = DATA_W'(32'h0000_0013);

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] resp_pc_q, resp_pc_d;
  logic [DATA_W-1:0] data_mem_q [DEPTH];
  logic [DATA_W-1:0] data_mem_d [DEPTH];
  logic [ADDR_W-1:0] addr_mem_q [DEPTH];
  logic [ADDR_W-1:0] addr_mem_d [DEPTH];
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [CW-1:0]     live_q, live_d;
  logic [CW-1:0]     drop_q, drop_d;

  logic              redirect_s;
  logic [ADDR_W-1:0] target_s;
  logic [SW-1:0]     credit_sum_s;
  logic              grant_s;
  logic              push_s;
  logic              pop_s;

  assign redirect_s   = jtag_reset_flag_i | jump_flag_i;
  assign target_s     = jtag_reset_flag_i ? RESET_PC : jump_addr_i;
  // Discarded responses still occupy credits: their slots must drain before reuse.
  assign credit_sum_s = SW'(count_q) + SW'(live_q) + SW'(drop_q);
  assign req_o        = !rst && !redirect_s && (credit_sum_s < SW'(DEPTH));
  assign addr_o       = fetch_pc_q;
  assign grant_s      = req_o & gnt_i;
  assign inst_valid_o = (count_q != CW'(0));
  assign push_s       = rvalid_i && !redirect_s && (drop_q == CW'(0));
  assign pop_s        = inst_valid_o && !hold_i && !redirect_s;
  assign inst_o       = inst_valid_o ? data_mem_q[rd_ptr_q] : NOP;
  assign inst_addr_o  = addr_mem_q[rd_ptr_q];
  assign level_o      = count_q;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    data_mem_d = data_mem_q;
    addr_mem_d = addr_mem_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    live_d     = live_q;
    drop_d     = drop_q;
    if (redirect_s) begin
      fetch_pc_d = target_s;
      resp_pc_d  = target_s;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      live_d     = '0;
      // Everything still in flight turns stale; a response landing now is one of them.
      drop_d     = drop_q + live_q - CW'(rvalid_i);
    end else begin
      if (grant_s) begin
        fetch_pc_d = fetch_pc_q + ADDR_W'(PC_STEP);
      end else begin
        fetch_pc_d = fetch_pc_q;
      end
      if (rvalid_i && (drop_q != CW'(0))) begin
        drop_d = drop_q - CW'(1);
      end else begin
        drop_d = drop_q;
      end
      if (push_s) begin
        data_mem_d[wr_ptr_q] = rdata_i;
        addr_mem_d[wr_ptr_q] = resp_pc_q;
        wr_ptr_d             = wr_ptr_q + PW'(1);
        resp_pc_d            = resp_pc_q + ADDR_W'(PC_STEP);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      count_d = count_q + CW'(push_s) - CW'(pop_s);
      live_d  = live_q + CW'(grant_s) - CW'(push_s);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      data_mem_q <= '{default: '0};
      addr_mem_q <= '{default: '0};
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      live_q     <= '0;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      data_mem_q <= data_mem_d;
      addr_mem_q <= addr_mem_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      live_q     <= live_d;
      drop_q     <= drop_d;
    end
  end

endmodule

// File: tb/tb_fetch_prefetch_buf.sv
// Bench for fetch_prefetch_buf: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_fetch_prefetch_buf;

  localparam int DEPTH = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        jump_flag_i = 1'b0;
  logic [31:0] jump_addr_i = 32'h0;
  logic        jtag_reset_flag_i = 1'b0;
  logic        hold_i = 1'b0;
  logic        gnt_i = 1'b1;
  logic        rvalid_i = 1'b0;
  logic [31:0] rdata_i = 32'h0;
  logic        req_o;
  logic [31:0] addr_o;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;
  logic [2:0]  level_o;

  fetch_prefetch_buf #(
    .ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .RESET_PC(32'h0), .PC_STEP(4)
  ) dut (
    .clk(clk), .rst(rst),
    .jump_flag_i(jump_flag_i), .jump_addr_i(jump_addr_i),
    .jtag_reset_flag_i(jtag_reset_flag_i), .hold_i(hold_i),
    .req_o(req_o), .addr_o(addr_o), .gnt_i(gnt_i),
    .rvalid_i(rvalid_i), .rdata_i(rdata_i),
    .inst_valid_o(inst_valid_o), .inst_o(inst_o), .inst_addr_o(inst_addr_o),
    .level_o(level_o)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; bit keep; } fl_t;
  typedef struct { logic [31:0] addr; int due; } bus_t;

  fl_t         m_infl[$];
  logic [31:0] m_fifo[$];
  logic [31:0] m_pc = 32'h0;
  bus_t        bus_q[$];
  int          cyc = 0;
  int          bus_lat = 1;
  bit          bus_en = 1'b1;
  int          tests = 0;
  int          fails = 0;
  logic [31:0] h;

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  function automatic bit m_req_f();
    return !(jump_flag_i || jtag_reset_flag_i) && ((m_fifo.size() + m_infl.size()) < DEPTH);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive_bus();
    if (bus_en && bus_q.size() > 0 && bus_q[0].due <= cyc) begin
      rvalid_i = 1'b1;
      rdata_i  = data_of(bus_q[0].addr);
    end else begin
      rvalid_i = 1'b0;
      rdata_i  = 32'h0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    drive_bus();
  endtask

  task automatic drain();
    gnt_i  = 1'b0;
    hold_i = 1'b0;
    bus_en = 1'b1;
    drive_bus();
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus_q.size() == 0 && m_fifo.size() == 0 && m_infl.size() == 0) break;
    end
    tests++;
    if (bus_q.size() != 0 || m_fifo.size() != 0 || m_infl.size() != 0) begin
      fails++;
      $display("FAIL drain_timeout: got %0d entries left, expected 0", bus_q.size() + m_fifo.size());
    end
  endtask

  task automatic wait_valid(input string nm);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (inst_valid_o) break;
      tick();
    end
    chk(nm, inst_valid_o, 1'b1);
  endtask

  // Reference model: FIFO of addresses and in-flight list with keep/discard marks.
  always @(posedge clk or posedge rst) begin
    bit  req;
    fl_t e;
    if (rst) begin
      m_fifo.delete();
      m_infl.delete();
      bus_q.delete();
      m_pc = 32'h0;
    end else begin
      req = m_req_f();
      if (rvalid_i && bus_q.size() > 0) bus_q.delete(0);
      if (jump_flag_i || jtag_reset_flag_i) begin
        if (rvalid_i && m_infl.size() > 0) m_infl.delete(0);
        foreach (m_infl[i]) m_infl[i].keep = 1'b0;
        m_fifo.delete();
        m_pc = jtag_reset_flag_i ? 32'h0 : jump_addr_i;
      end else begin
        if (m_fifo.size() > 0 && !hold_i) m_fifo.delete(0);
        if (rvalid_i) begin
          if (m_infl.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL spurious_rvalid: got a response, expected none in flight");
          end else begin
            e = m_infl[0];
            m_infl.delete(0);
            if (e.keep) m_fifo.push_back(e.addr);
          end
        end
        if (req && gnt_i) begin
          m_infl.push_back('{m_pc, 1'b1});
          m_pc = m_pc + 32'd4;
        end
      end
      cyc++;
    end
  end

  // Per-cycle comparison against the model; also logs grants for the bus model.
  always @(negedge clk) begin
    bit er;
    if (!rst) begin
      er = m_req_f();
      chk("req_o", req_o, er);
      if (er) chk("addr_o", addr_o, m_pc);
      chk("inst_valid_o", inst_valid_o, m_fifo.size() > 0);
      chk("level_o", level_o, m_fifo.size());
      if (m_fifo.size() > 0) begin
        chk("inst_addr_o", inst_addr_o, m_fifo[0]);
        chk("inst_o", inst_o, data_of(m_fifo[0]));
      end else begin
        chk("inst_o_nop", inst_o, NOP);
      end
      if (req_o && gnt_i) bus_q.push_back('{addr_o, cyc + bus_lat});
    end
  end

  initial begin
    #200000;
    fails++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    // Reset state
    tick();
    chk("rst_req", req_o, 1'b0);
    chk("rst_valid", inst_valid_o, 1'b0);
    chk("rst_inst", inst_o, NOP);
    chk("rst_level", level_o, 3'd0);
    tick();
    rst = 1'b0;
    drive_bus();

    // 1: streaming with 1-cycle bus latency
    @(negedge clk);
    chk("t1_req", req_o, 1'b1);
    chk("t1_addr0", addr_o, 32'h0);
    tick();
    @(negedge clk);
    chk("t1_valid_early", inst_valid_o, 1'b0);
    chk("t1_addr1", addr_o, 32'h4);
    tick();
    @(negedge clk);
    chk("t1_valid", inst_valid_o, 1'b1);
    chk("t1_iaddr0", inst_addr_o, 32'h0);
    chk("t1_inst0", inst_o, 32'h5A5A_0000);
    tick();
    @(negedge clk);
    chk("t1_iaddr1", inst_addr_o, 32'h4);
    tick();
    @(negedge clk);
    chk("t1_iaddr2", inst_addr_o, 32'h8);

    // 2: hold fills the FIFO, release drains one word per cycle
    tick();
    hold_i = 1'b1;
    repeat (8) tick();
    @(negedge clk);
    chk("t2_level_full", level_o, 3'd4);
    chk("t2_req_off", req_o, 1'b0);
    h = m_fifo[0];
    tick();
    hold_i = 1'b0;
    repeat (4) tick();
    @(negedge clk);
    chk("t2_drained", inst_addr_o, h + 32'd16);

    // 3: jump with three reads in flight
    drain();
    tick();
    jtag_reset_flag_i = 1'b1;
    tick();
    jtag_reset_flag_i = 1'b0;
    gnt_i  = 1'b1;
    bus_en = 1'b0;
    drive_bus();
    tick();
    tick();
    tick();
    jump_flag_i = 1'b1;
    jump_addr_i = 32'h100;
    @(negedge clk);
    chk("t3_req_redirect", req_o, 1'b0);
    tick();
    jump_flag_i = 1'b0;
    bus_en = 1'b1;
    drive_bus();
    @(negedge clk);
    chk("t3_level", level_o, 3'd0);
    chk("t3_req", req_o, 1'b1);
    chk("t3_addr", addr_o, 32'h100);
    wait_valid("t3_valid");
    chk("t3_iaddr", inst_addr_o, 32'h100);
    chk("t3_inst", inst_o, 32'h5A5A_0100);

    // 4: response coincident with jump is dropped
    drain();
    tick();
    gnt_i  = 1'b1;
    bus_en = 1'b0;
    drive_bus();
    tick();
    tick();
    tick();
    bus_en      = 1'b1;
    jump_flag_i = 1'b1;
    jump_addr_i = 32'h200;
    drive_bus();
    @(negedge clk);
    chk("t4_rvalid_now", rvalid_i, 1'b1);
    chk("t4_req_redirect", req_o, 1'b0);
    tick();
    jump_flag_i = 1'b0;
    @(negedge clk);
    chk("t4_req", req_o, 1'b1);
    chk("t4_addr", addr_o, 32'h200);
    wait_valid("t4_valid");
    chk("t4_iaddr", inst_addr_o, 32'h200);
    chk("t4_inst", inst_o, 32'h5A5A_0200);

    // 5: jtag reset wins over a simultaneous jump
    drain();
    tick();
    gnt_i             = 1'b1;
    jump_flag_i       = 1'b1;
    jtag_reset_flag_i = 1'b1;
    jump_addr_i       = 32'h80;
    tick();
    jump_flag_i       = 1'b0;
    jtag_reset_flag_i = 1'b0;
    @(negedge clk);
    chk("t5_req", req_o, 1'b1);
    chk("t5_addr", addr_o, 32'h0);
    wait_valid("t5_valid");
    chk("t5_iaddr", inst_addr_o, 32'h0);

    // 6: asynchronous reset mid-burst
    bus_lat = 3;
    repeat (6) tick();
    @(negedge clk);
    chk("t6_outstanding", (m_infl.size() >= 2), 1'b1);
    tick();
    rst      = 1'b1;
    rvalid_i = 1'b0;
    #1;
    chk("t6_req", req_o, 1'b0);
    chk("t6_valid", inst_valid_o, 1'b0);
    chk("t6_inst", inst_o, NOP);
    chk("t6_level", level_o, 3'd0);
    tick();
    tick();
    rst     = 1'b0;
    bus_lat = 1;
    drive_bus();
    @(negedge clk);
    chk("t6_req_after", req_o, 1'b1);
    chk("t6_addr_after", addr_o, 32'h0);
    repeat (10) tick();
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
